// File: rtl/ro_pair_counter.sv
// rtl/ro_pair_counter.sv - ring-oscillator pair edge counter producing one PUF response bit
// Enables both oscillators, counts their rising edges over a fixed clk window, compares.
module ro_pair_counter #(
    parameter int CNT_WIDTH = 16,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic                 ro_enable,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count_a,
    output logic [CNT_WIDTH-1:0] count_b,
    output logic                 response,
    output logic                 tie
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // bit 0 = first sync flop, bit 1 = second sync flop, bit 2 = history
    logic [2:0] sh_a;
    logic [2:0] sh_b;
    logic       edge_a;
    logic       edge_b;

    logic [TW-1:0]        timer;
    logic                 settle_end;
    logic                 window_end;
    logic [CNT_WIDTH-1:0] cnt_a;
    logic [CNT_WIDTH-1:0] cnt_b;
    logic [CNT_WIDTH-1:0] cnt_a_next;
    logic [CNT_WIDTH-1:0] cnt_b_next;

    assign edge_a     = sh_a[1] & ~sh_a[2];
    assign edge_b     = sh_b[1] & ~sh_b[2];
    assign settle_end = (timer == TW'(SETTLE - 1));
    assign window_end = (timer == TW'(WINDOW - 1));
    assign cnt_a_next = (edge_a && cnt_a != CNT_MAX) ? cnt_a + CNT_WIDTH'(1) : cnt_a;
    assign cnt_b_next = (edge_b && cnt_b != CNT_MAX) ? cnt_b + CNT_WIDTH'(1) : cnt_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control outputs decode straight from the state so reset drops ro_enable immediately.
    always_comb begin
        state_next = state;
        ro_enable  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                ro_enable = 1'b1;
                if (settle_end) begin
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                ro_enable = 1'b1;
                if (window_end) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a <= '0;
            sh_b <= '0;
        end else begin
            sh_a <= {sh_a[1:0], ro_a};
            sh_b <= {sh_b[1:0], ro_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer    <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            count_a  <= '0;
            count_b  <= '0;
            response <= 1'b0;
            tie      <= 1'b0;
        end else begin
            if ((state == ST_SETTLE || state == ST_COUNT) && state_next == state) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end

            if (state == ST_COUNT) begin
                cnt_a <= cnt_a_next;
                cnt_b <= cnt_b_next;
            end else begin
                cnt_a <= '0;
                cnt_b <= '0;
            end

            // Results load on the final window edge so they are already valid while done is high.
            if (state == ST_COUNT && window_end) begin
                count_a  <= cnt_a_next;
                count_b  <= cnt_b_next;
                response <= (cnt_a_next > cnt_b_next);
                tie      <= (cnt_a_next == cnt_b_next);
            end
        end
    end

endmodule

// File: tb/tb_ro_pair_counter.sv
// tb/tb_ro_pair_counter.sv - randomized self-checking bench for ro_pair_counter
module tb_ro_pair_counter;

    localparam int S  = 4;
    localparam int W  = 1024;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start8 = 1'b0;
    logic ro_a = 1'b0;
    logic ro_b = 1'b0;
    logic ro_c = 1'b0;
    logic zero8 = 1'b0;

    logic          ro_enable, busy, done, response, tie;
    logic [CW-1:0] count_a, count_b;
    logic          ro_enable8, busy8, done8, response8, tie8;
    logic [7:0]    count_a8, count_b8;

    int checks = 0;
    int errors = 0;

    ro_pair_counter #(.CNT_WIDTH(CW), .WINDOW(W), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .ro_enable(ro_enable), .busy(busy), .done(done),
        .count_a(count_a), .count_b(count_b), .response(response), .tie(tie)
    );

    ro_pair_counter #(.CNT_WIDTH(8), .WINDOW(W), .SETTLE(S)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .ro_a(ro_c), .ro_b(zero8),
        .ro_enable(ro_enable8), .busy(busy8), .done(done8),
        .count_a(count_a8), .count_b(count_b8), .response(response8), .tie(tie8)
    );

    always #5 clk = ~clk;

    // Oscillator sources: half-periods in 5 ns steps on a grid offset by 1 ns from clk edges.
    int ha = 0, hb = 0, hc = 3;
    int pa = 0, pb = 0, pc = 0;
    bit same = 1'b0;
    initial begin
        #1;
        forever begin
            #5;
            if (ha == 0) ro_a = 1'b0;
            else if (++pa >= ha) begin ro_a = ~ro_a; pa = 0; end
            if (same) ro_b = ro_a;
            else if (hb == 0) ro_b = 1'b0;
            else if (++pb >= hb) begin ro_b = ~ro_b; pb = 0; end
            if (++pc >= hc) begin ro_c = ~ro_c; pc = 0; end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model: oscillator level as seen at each clk edge, measurement schedule from start.
    bit sa [0:65535];
    bit sb [0:65535];
    int cyc = 0;
    int e0 = 0;
    bit m_active = 1'b0;
    logic          exp_busy = 0, exp_en = 0, exp_done = 0, exp_resp = 0, exp_tie = 0;
    logic [CW-1:0] exp_ca = '0, exp_cb = '0;

    function automatic int rises(input bit which, input int lo, input int hi);
        int n = 0;
        for (int j = lo; j <= hi; j++) begin
            if (which ? (sb[j] && !sb[j-1]) : (sa[j] && !sa[j-1])) n++;
        end
        return n;
    endfunction

    task automatic model_clear();
        m_active = 1'b0;
        exp_busy = 0; exp_en = 0; exp_done = 0; exp_resp = 0; exp_tie = 0;
        exp_ca = '0; exp_cb = '0;
    endtask

    always @(posedge rst) model_clear();

    always @(posedge clk) begin
        int k, na, nb;
        cyc++;
        sa[cyc] = rst ? 1'b0 : ro_a;
        sb[cyc] = rst ? 1'b0 : ro_b;
        if (rst) begin
            model_clear();
        end else begin
            if (m_active && (cyc - 1 - e0) == S + W) m_active = 1'b0;
            else if (!m_active && start) begin m_active = 1'b1; e0 = cyc; end
            k = cyc - e0;
            exp_busy = m_active;
            exp_en   = m_active && (k < S + W);
            exp_done = m_active && (k == S + W);
            if (exp_done) begin
                na = rises(1'b0, e0 + S - 1, e0 + S + W - 2);
                nb = rises(1'b1, e0 + S - 1, e0 + S + W - 2);
                if (na > 65535) na = 65535;
                if (nb > 65535) nb = 65535;
                exp_ca   = CW'(na);
                exp_cb   = CW'(nb);
                exp_resp = (na > nb);
                exp_tie  = (na == nb);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, exp_busy);
        chk("ro_enable", ro_enable, exp_en);
        chk("done", done, exp_done);
        chk("count_a", count_a, exp_ca);
        chk("count_b", count_b, exp_cb);
        chk("response", response, exp_resp);
        chk("tie", tie, exp_tie);
    end

    // One measurement: optional start re-pulses at cycles p1/p2, then watch extra cycles after done.
    task automatic run(input int p1, input int p2, input int watch,
                       output int lat, output int en, output int nd);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; en = 0; nd = 0;
        for (int n = 1; n <= 1100 + watch; n++) begin
            start = (n == p1 || n == p2);
            if (ro_enable) en++;
            if (done) begin
                nd++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n >= lat + watch) break;
            @(negedge clk);
        end
        start = 1'b0;
        if (lat < 0) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int lat, en, nd, pa_cnt, pb_cnt, d;
        int dt [3];
        repeat (3) @(negedge clk);
        chk("rst_ro_enable", ro_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count_a", count_a, 0);
        chk("rst_response", response, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 40 ns vs 60 ns, plus saturating 8-bit instance on 30 ns
        ha = 4; hb = 6;
        start8 = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; start8 = 1'b0;
        lat = -1; en = 0;
        for (int n = 1; n <= 1100; n++) begin
            if (ro_enable) en++;
            if (done) begin lat = n; break; end
            @(negedge clk);
        end
        chk("latency", lat, 1029);
        chk("enable_cycles", en, 1028);
        chk_range("t1_count_a", count_a, 255, 257);
        chk_range("t1_count_b", count_b, 169, 172);
        chk("t1_response", response, 1);
        chk("t1_tie", tie, 0);
        chk("sat_done", done8, 1);
        chk("sat_count_a", count_a8, 255);
        chk("sat_count_b", count_b8, 0);
        chk("sat_response", response8, 1);
        chk("sat_tie", tie8, 0);
        pa_cnt = count_a; pb_cnt = count_b;
        @(negedge clk);

        // swapped periods
        ha = 6; hb = 4;
        run(0, 0, 0, lat, en, nd);
        d = int'(count_a) - pb_cnt;
        chk("swap_a_close", (d >= -1 && d <= 1), 1);
        d = int'(count_b) - pa_cnt;
        chk("swap_b_close", (d >= -1 && d <= 1), 1);
        chk("swap_response", response, 0);
        chk("swap_tie", tie, 0);

        // shared phase-aligned 50 ns source
        ha = 5; same = 1'b1;
        run(0, 0, 0, lat, en, nd);
        chk_range("same_count", count_a, 203, 207);
        chk("same_tie", tie, 1);
        chk("same_response", response, 0);
        same = 1'b0;

        // start re-pulsed mid-measurement
        ha = 4; hb = 7;
        run(10, 500, 1100, lat, en, nd);
        chk("repulse_dones", nd, 1);
        chk("repulse_latency", lat, 1029);

        // reset during COUNT
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ro_enable", ro_enable, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_count_a", count_a, 0);
        chk("rst_mid_tie", tie, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ha = 3; hb = 9;
        run(0, 0, 0, lat, en, nd);
        chk("post_rst_latency", lat, 1029);

        // start held high: back-to-back measurements
        nd = 0;
        start = 1'b1;
        for (int n = 0; n < 3300 && nd < 3; n++) begin
            @(negedge clk);
            if (done) begin dt[nd] = n; nd++; end
        end
        start = 1'b0;
        chk("held_dones", nd, 3);
        chk("held_spacing1", dt[1] - dt[0], 1030);
        chk("held_spacing2", dt[2] - dt[1], 1030);
        repeat (1100) @(negedge clk);

        // randomized periods, including dead oscillators
        for (int r = 0; r < 4; r++) begin
            ha = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(3, 10));
            hb = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(3, 10));
            run(int'($urandom_range(1, 1000)), 0, 0, lat, en, nd);
            if (ha == 0) chk("dead_a", count_a, 0);
            if (hb == 0) chk("dead_b", count_b, 0);
        end
        ha = 0; hb = 0;
        run(0, 0, 0, lat, en, nd);
        chk("dead_both_count_a", count_a, 0);
        chk("dead_both_tie", tie, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Measurement end of the ring-oscillator PUF: enables a pair of ring oscillators, counts rising edges of each over a fixed window of system clocks, and produces one response bit from the comparison.
- Sits between two ring_osc instances (driving their enable input, sampling their outputs) and the challenge/response controller, which uses a start/done handshake.

Parameters:
- CNT_WIDTH, 16, width of each edge counter and count output.
- WINDOW, 1024, number of clk cycles in the counting window (>=1).
- SETTLE, 4, clk cycles between ro_enable rising and window open (>=3, covers synchronizer flush and oscillator start-up).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a measurement; sampled only in IDLE.
- ro_a  input  1  output of oscillator A, asynchronous to clk.
- ro_b  input  1  output of oscillator B, asynchronous to clk.
- ro_enable  output  1  drives enable of both oscillators.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when results update.
- count_a  output  CNT_WIDTH  edges counted on ro_a in the last window.
- count_b  output  CNT_WIDTH  edges counted on ro_b in the last window.
- response  output  1  1 when count_a > count_b, else 0.
- tie  output  1  1 when count_a == count_b.

Behaviour:
- Reset (async, any state): state=IDLE. ro_enable, busy, done, response and tie = 0. count_a, count_b, internal counters and synchronizer flops = 0.
- Input conditioning, per oscillator:
  - 2-flop synchronizer plus one history flop.
  - edge = sync2 & ~hist.
  - Valid only for oscillator frequency < clk/2. Faster inputs alias and the block does not detect this.
- FSM states: IDLE, SETTLE, COUNT, DONE.
- IDLE:
  - ro_enable=0, busy=0.
  - start=1 -> SETTLE next cycle.
  - Start is level-sampled; holding it high re-triggers on return to IDLE.
- SETTLE:
  - ro_enable=1, busy=1.
  - Internal counters held at 0.
  - Timer runs SETTLE cycles, then -> COUNT.
- COUNT:
  - ro_enable=1.
  - Each cycle, an internal counter increments when its edge=1.
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - After exactly WINDOW cycles -> DONE.
- DONE (1 cycle):
  - ro_enable=0.
  - count_a/count_b <= internal counters; response <= (a>b); tie <= (a==b).
  - done=1 for this single cycle; next state IDLE.
- Latency: start sampled high at cycle 0 -> done high at cycle 1+SETTLE+WINDOW.
- ro_enable is high for exactly SETTLE+WINDOW cycles per measurement.
- Outputs count_a, count_b, response and tie hold their values from DONE until the next DONE or reset.
- start while busy=1 is ignored: no queueing, no restart.
- Edges detected outside COUNT are discarded. This includes residual synchronizer pulses after ro_enable falls.
- Window is counted in clk cycles only, independent of oscillator activity. A dead oscillator yields a count of 0.
- Reset mid-measurement: immediate return to IDLE, ro_enable drops asynchronously, no done pulse, outputs cleared.

Test Plan:
- clk 10 ns, ro_a period 40 ns, ro_b period 60 ns, defaults, one start pulse:
  - done exactly 1029 cycles after start.
  - count_a in 255..257; count_b in 169..172.
  - response=1, tie=0.
  - ro_enable high 1028 cycles.
- Swap periods (ro_a 60 ns, ro_b 40 ns) -> response=0, tie=0, counts swapped within ±1.
- ro_a and ro_b driven by the same 50 ns source, phase-aligned -> count_a == count_b (≈205), tie=1, response=0.
- CNT_WIDTH=8, ro_a period 30 ns, ro_b held at 0 -> count_a=255 (saturated, no wrap), count_b=0, response=1.
- start re-pulsed at cycles 10 and 500 of a measurement:
  - exactly one done pulse.
  - Then assert rst at COUNT cycle 300 of a second run: ro_enable=0 in the same cycle, all outputs 0, no done, next start works normally.
- start held high continuously -> back-to-back measurements, a done pulse every 1030 cycles.
